mult_unit: RTL and testbench



---
 rtl/mult_unit.sv | 136 +++++++++++++
 tb/tb_mult_unit.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_unit.sv
// Iterative RV32M multiplier for MUL, MULH, MULHSU and MULHU.
// Uses a shift-add datapath that retires BITS_PER_CYCLE multiplier bits per clock.
package common_types_pkg;
  typedef enum logic [2:0] {
    ADD_SUB_MUL = 3'b000,
    SLL_MULH    = 3'b001,
    SLT_MULHSU  = 3'b010,
    SLTU_MULHU  = 3'b011
  } funct3_r_t;
endpackage

module mult_unit
  import common_types_pkg::*;
#(
  parameter int WORD_W         = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic              flush,
  input  logic [2:0]        funct3,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] result
);

  localparam int BPC   = BITS_PER_CYCLE;
  localparam int STEPS = WORD_W / BPC;
  localparam int CNT_W = $clog2(STEPS + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]    count;
  logic [2*WORD_W-1:0] prod;
  logic [2*WORD_W-1:0] prod_fix;
  logic [WORD_W-1:0]   mcand;
  logic [WORD_W-1:0]   mplier;
  logic [WORD_W-1:0]   mag_a;
  logic [WORD_W-1:0]   mag_b;
  logic [WORD_W+BPC-1:0] acc;
  logic neg, hi_sel;
  logic sgn_a, sgn_b, hi_dec;
  logic last_step;

  always_comb begin
    sgn_a  = 1'b0;
    sgn_b  = 1'b0;
    hi_dec = 1'b0;
    unique case (1'b1)
      (funct3 == SLL_MULH): begin
        sgn_a  = 1'b1;
        sgn_b  = 1'b1;
        hi_dec = 1'b1;
      end
      (funct3 == SLT_MULHSU): begin
        sgn_a  = 1'b1;
        hi_dec = 1'b1;
      end
      (funct3 == SLTU_MULHU): hi_dec = 1'b1;
      default: ;
    endcase
  end

  // 0x80000000 negates to itself, which is its correct unsigned magnitude
  assign mag_a = (sgn_a && a[WORD_W-1]) ? -a : a;
  assign mag_b = (sgn_b && b[WORD_W-1]) ? -b : b;

  assign acc = {{BPC{1'b0}}, prod[2*WORD_W-1:WORD_W]}
             + ({{BPC{1'b0}}, mcand}
             *  {{WORD_W{1'b0}}, mplier[BPC-1:0]});

  assign prod_fix  = neg ? -prod : prod;
  assign last_step = (count == CNT_W'(STEPS - 1));
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (last_step) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      count  <= '0;
      prod   <= '0;
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
      hi_sel <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      if (!flush) begin
        unique case (state)
          IDLE: if (start) begin
            mcand  <= mag_a;
            mplier <= mag_b;
            neg    <= (sgn_a && a[WORD_W-1])
                    ^ (sgn_b && b[WORD_W-1]);
            hi_sel <= hi_dec;
            prod   <= '0;
            count  <= '0;
          end
          CALC: begin
            prod   <= {acc, prod[WORD_W-1:BPC]};
            mplier <= mplier >> BPC;
            count  <= count + 1'b1;
          end
          FIX: begin
            result <= hi_sel ? prod_fix[2*WORD_W-1:WORD_W]
                             : prod_fix[WORD_W-1:0];
            done   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit, covering BITS_PER_CYCLE of 1 and 4.
// Expected results are queued at issue and popped when done is seen.
module tb_mult_unit;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic start = 1'b0;
  logic start4 = 1'b0;
  logic flush = 1'b0;
  logic [2:0] funct3 = 3'b000;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic busy, done, busy4, done4;
  logic [31:0] result, result4;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  mult_unit #(.WORD_W(32), .BITS_PER_CYCLE(1)) u_dut (
    .clk(clk), .nrst(nrst), .start(start), .flush(flush),
    .funct3(funct3), .a(a), .b(b),
    .busy(busy), .done(done), .result(result)
  );

  mult_unit #(.WORD_W(32), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .nrst(nrst), .start(start4), .flush(flush),
    .funct3(funct3), .a(a), .b(b),
    .busy(busy4), .done(done4), .result(result4)
  );

  task automatic issue(input bit sel4, input logic [2:0] f,
                       input logic [31:0] x, input logic [31:0] y,
                       input bit push, input logic [31:0] e);
    funct3 = f;
    a = x;
    b = y;
    if (sel4) start4 = 1'b1;
    else      start  = 1'b1;
    if (push) exp_q.push_back(e);
    @(posedge clk); #1;
    start  = 1'b0;
    start4 = 1'b0;
    a = $urandom;
    b = $urandom;
    funct3 = 3'($urandom);
  endtask

  task automatic wait_done(input bit sel4, output int cyc,
                           output int bcnt, output logic [31:0] res);
    cyc  = -1;
    res  = 'x;
    bcnt = (sel4 ? busy4 : busy) ? 1 : 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (sel4 ? done4 : done) begin
        cyc = i;
        res = sel4 ? result4 : result;
        break;
      end
      if (sel4 ? busy4 : busy) bcnt++;
    end
  endtask

  function automatic logic [31:0] pop_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  task automatic test_reset();
    #3;
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL reset_busy got=%b exp=0", busy);
    end
    checks++;
    if (done !== 1'b0) begin
      failures++; $display("FAIL reset_done got=%b exp=0", done);
    end
    checks++;
    if (result !== 32'h0) begin
      failures++; $display("FAIL reset_result got=%h exp=0", result);
    end
    @(negedge clk); #2;
    nrst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int cyc, bc;
    logic [31:0] res, e;
    issue(1'b0, 3'b000, 32'd7, 32'd6, 1'b1, 32'h2A);
    wait_done(1'b0, cyc, bc, res);
    e = pop_exp();
    checks++;
    if (res !== e) begin
      failures++; $display("FAIL basic_result got=%h exp=%h", res, e);
    end
    checks++;
    if (cyc !== 33) begin
      failures++; $display("FAIL basic_latency got=%0d exp=33", cyc);
    end
    checks++;
    if (bc !== 33) begin
      failures++; $display("FAIL basic_busy_cycles got=%0d exp=33", bc);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL basic_busy_in_done got=%b exp=0", busy);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      failures++; $display("FAIL basic_done_width got=%b exp=0", done);
    end
  endtask

  task automatic test_ops(input bit sel4, input int lat);
    logic [2:0]  fv [6] = '{3'b000, 3'b000, 3'b001,
                            3'b001, 3'b011, 3'b010};
    logic [31:0] av [6] = '{32'd7, 32'hFFFFFFFD, 32'hFFFFFFFD,
                            32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] bv [6] = '{32'd6, 32'd5, 32'd5,
                            32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] ev [6] = '{32'h2A, 32'hFFFFFFF1, 32'hFFFFFFFF,
                            32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF};
    int cyc, bc;
    logic [31:0] res, e;
    for (int i = 0; i < 6; i++) begin
      issue(sel4, fv[i], av[i], bv[i], 1'b1, ev[i]);
      wait_done(sel4, cyc, bc, res);
      e = pop_exp();
      checks++;
      if (res !== e) begin
        failures++;
        $display("FAIL ops%0d_%0d_result got=%h exp=%h", lat, i, res, e);
      end
      checks++;
      if (cyc !== lat) begin
        failures++;
        $display("FAIL ops%0d_%0d_latency got=%0d exp=%0d", lat, i, cyc, lat);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc, bc, nd;
    logic [31:0] res, e;
    nd = 0;
    issue(1'b0, 3'b000, 32'd3, 32'd4, 1'b1, 32'd12);
    repeat (4) begin @(posedge clk); #1; end
    funct3 = 3'b000; a = 32'd5; b = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(1'b0, cyc, bc, res);
    if (cyc > 0) nd++;
    e = pop_exp();
    checks++;
    if (res !== e) begin
      failures++; $display("FAIL b2b_first_result got=%h exp=%h", res, e);
    end
    checks++;
    if (cyc !== 28) begin
      failures++; $display("FAIL b2b_first_latency got=%0d exp=28", cyc);
    end
    issue(1'b0, 3'b011, 32'd2, 32'd3, 1'b1, 32'd0);
    wait_done(1'b0, cyc, bc, res);
    if (cyc > 0) nd++;
    e = pop_exp();
    checks++;
    if (res !== e) begin
      failures++; $display("FAIL b2b_second_result got=%h exp=%h", res, e);
    end
    checks++;
    if (cyc !== 33) begin
      failures++; $display("FAIL b2b_second_latency got=%0d exp=33", cyc);
    end
    repeat (40) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    checks++;
    if (nd !== 2) begin
      failures++; $display("FAIL b2b_done_pulses got=%0d exp=2", nd);
    end
  endtask

  task automatic test_flush();
    int cyc, bc, nd;
    logic [31:0] res, e;
    issue(1'b0, 3'b000, 32'd5, 32'd7, 1'b1, 32'd35);
    wait_done(1'b0, cyc, bc, res);
    e = pop_exp();
    checks++;
    if (res !== e) begin
      failures++; $display("FAIL flush_prior_result got=%h exp=%h", res, e);
    end
    issue(1'b0, 3'b001, 32'hFFFF0000, 32'd3, 1'b0, 32'd0);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL flush_busy got=%b exp=0", busy);
    end
    nd = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    checks++;
    if (nd !== 0) begin
      failures++; $display("FAIL flush_no_done got=%0d exp=0", nd);
    end
    checks++;
    if (result !== 32'd35) begin
      failures++; $display("FAIL flush_result_kept got=%h exp=23", result);
    end
    funct3 = 3'b000; a = 32'd2; b = 32'd2;
    start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL flush_start_busy got=%b exp=0", busy);
    end
    issue(1'b0, 3'b000, 32'd3, 32'd3, 1'b0, 32'd0);
    repeat (32) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (done !== 1'b0) begin
      failures++; $display("FAIL fix_flush_done got=%b exp=0", done);
    end
    checks++;
    if (result !== 32'd35) begin
      failures++; $display("FAIL fix_flush_result got=%h exp=23", result);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL fix_flush_busy got=%b exp=0", busy);
    end
    issue(1'b0, 3'b000, 32'd9, 32'd9, 1'b1, 32'd81);
    wait_done(1'b0, cyc, bc, res);
    e = pop_exp();
    checks++;
    if (res !== e) begin
      failures++; $display("FAIL flush_after_result got=%h exp=%h", res, e);
    end
    checks++;
    if (cyc !== 33) begin
      failures++; $display("FAIL flush_after_latency got=%0d exp=33", cyc);
    end
  endtask

  task automatic test_async_reset();
    int cyc, bc;
    logic [31:0] res, e;
    issue(1'b0, 3'b011, 32'hFFFFFFFF, 32'h3, 1'b0, 32'd0);
    repeat (10) begin @(posedge clk); #1; end
    #2;
    nrst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL areset_busy got=%b exp=0", busy);
    end
    checks++;
    if (done !== 1'b0) begin
      failures++; $display("FAIL areset_done got=%b exp=0", done);
    end
    checks++;
    if (result !== 32'h0) begin
      failures++; $display("FAIL areset_result got=%h exp=0", result);
    end
    @(negedge clk); #2;
    nrst = 1'b1;
    @(posedge clk); #1;
    issue(1'b0, 3'b000, 32'h10000, 32'h10000, 1'b1, 32'h0);
    wait_done(1'b0, cyc, bc, res);
    e = pop_exp();
    checks++;
    if (res !== e) begin
      failures++; $display("FAIL areset_mul got=%h exp=%h", res, e);
    end
    issue(1'b0, 3'b011, 32'h10000, 32'h10000, 1'b1, 32'h1);
    wait_done(1'b0, cyc, bc, res);
    e = pop_exp();
    checks++;
    if (res !== e) begin
      failures++; $display("FAIL areset_mulhu got=%h exp=%h", res, e);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_ops(1'b0, 33);
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_ops(1'b1, 9);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
